// File: rtl/dual_ball_motion.sv
// Two-ball motion controller: keyboard-steered balls that bounce off the
// playfield edges, advancing one step per synchronized VSync rising edge.
module dual_ball_motion #(
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int X2_START = 160,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int STEP     = 1,
  parameter int SIZE     = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball2X,
  output logic [9:0] Ball2Y,
  output logic [9:0] Ball_size
);

  localparam logic [9:0] StepPos = 10'(STEP);
  localparam logic [9:0] StepNeg = ~StepPos + 10'd1;

  // {hit, x motion, y motion} for a single key slot against one ball's key map
  function automatic logic [20:0] key_motion(input logic [7:0] k, input logic [7:0] k_up,
                                             input logic [7:0] k_dn, input logic [7:0] k_lf,
                                             input logic [7:0] k_rt);
    logic [20:0] res;
    res = '0;
    if (k == k_up)      res = {1'b1, 10'd0, StepNeg};
    else if (k == k_dn) res = {1'b1, 10'd0, StepPos};
    else if (k == k_lf) res = {1'b1, StepNeg, 10'd0};
    else if (k == k_rt) res = {1'b1, StepPos, 10'd0};
    return res;
  endfunction

  // Edge bounce overrides the key; 11-bit compare keeps pos-SIZE from underflowing
  function automatic logic [9:0] bound(input logic [9:0] pos, input logic [9:0] mot,
                                       input int lo, input int hi);
    logic [9:0] res;
    res = mot;
    if (({1'b0, pos} + 11'(SIZE)) >= 11'(hi))  res = StepNeg;
    else if ({1'b0, pos} <= 11'(lo + SIZE))    res = StepPos;
    return res;
  endfunction

  logic       r_sync1, r_sync2, r_sync3;
  logic [9:0] r_b1_x, r_b1_y, r_b2_x, r_b2_y;
  logic [9:0] r_b1_mx, r_b1_my, r_b2_mx, r_b2_my;

  logic        w_frame_tick;
  logic [20:0] w_b1_k0, w_b1_k1, w_b2_k0, w_b2_k1;
  logic [9:0]  w_b1_kx, w_b1_ky, w_b2_kx, w_b2_ky;
  logic [9:0]  w_b1_mx, w_b1_my, w_b2_mx, w_b2_my;

  assign w_frame_tick = r_sync2 & ~r_sync3;

  assign w_b1_k0 = key_motion(keycode0, 8'h1A, 8'h16, 8'h04, 8'h07);
  assign w_b1_k1 = key_motion(keycode1, 8'h1A, 8'h16, 8'h04, 8'h07);
  assign w_b2_k0 = key_motion(keycode0, 8'h52, 8'h51, 8'h50, 8'h4F);
  assign w_b2_k1 = key_motion(keycode1, 8'h52, 8'h51, 8'h50, 8'h4F);

  // Key decode per ball: slot 0 first, then slot 1, else keep the old motion
  always_comb begin
    w_b1_kx = r_b1_mx;
    w_b1_ky = r_b1_my;
    w_b2_kx = r_b2_mx;
    w_b2_ky = r_b2_my;
    if (w_b1_k0[20])      {w_b1_kx, w_b1_ky} = w_b1_k0[19:0];
    else if (w_b1_k1[20]) {w_b1_kx, w_b1_ky} = w_b1_k1[19:0];
    if (w_b2_k0[20])      {w_b2_kx, w_b2_ky} = w_b2_k0[19:0];
    else if (w_b2_k1[20]) {w_b2_kx, w_b2_ky} = w_b2_k1[19:0];
  end

  assign w_b1_mx = bound(r_b1_x, w_b1_kx, X_MIN, X_MAX);
  assign w_b1_my = bound(r_b1_y, w_b1_ky, Y_MIN, Y_MAX);
  assign w_b2_mx = bound(r_b2_x, w_b2_kx, X_MIN, X_MAX);
  assign w_b2_my = bound(r_b2_y, w_b2_ky, Y_MIN, Y_MAX);

  // VSync synchronizer, edge-detect flop, and per-frame position/motion update
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_b1_x  <= 10'(X_CENTER);
      r_b1_y  <= 10'(Y_CENTER);
      r_b2_x  <= 10'(X2_START);
      r_b2_y  <= 10'(Y_CENTER);
      r_b1_mx <= '0;
      r_b1_my <= '0;
      r_b2_mx <= '0;
      r_b2_my <= '0;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_frame_tick) begin
        r_b1_mx <= w_b1_mx;
        r_b1_my <= w_b1_my;
        r_b2_mx <= w_b2_mx;
        r_b2_my <= w_b2_my;
        r_b1_x  <= r_b1_x + w_b1_mx;
        r_b1_y  <= r_b1_y + w_b1_my;
        r_b2_x  <= r_b2_x + w_b2_mx;
        r_b2_y  <= r_b2_y + w_b2_my;
      end
    end
  end

  assign BallX     = r_b1_x;
  assign BallY     = r_b1_y;
  assign Ball2X    = r_b2_x;
  assign Ball2Y    = r_b2_y;
  assign Ball_size = 10'(SIZE);

endmodule

// File: tb/tb_dual_ball_motion.sv
// Randomized bench for dual_ball_motion against a frame-level behavioural model.
module tb_dual_ball_motion;

  localparam int XC = 320, YC = 240, X2 = 160;
  localparam int XLO = 0, XHI = 639, YLO = 0, YHI = 479;
  localparam int ST = 1, SZ = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode0 = 8'h00;
  logic [7:0] keycode1 = 8'h00;
  logic [9:0] BallX, BallY, Ball2X, Ball2Y, Ball_size;

  dual_ball_motion dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .keycode0 (keycode0),
    .keycode1 (keycode1),
    .BallX    (BallX),
    .BallY    (BallY),
    .Ball2X   (Ball2X),
    .Ball2Y   (Ball2Y),
    .Ball_size(Ball_size)
  );

  always #10 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: positions/motions as plain integers, VSync samples as a short history
  int m_x[2], m_y[2], m_mx[2], m_my[2];
  bit h1, h2, h3;
  bit m_tick;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_key(input int b, input logic [7:0] k, output bit hit,
                                    output int mx, output int my);
    logic [7:0] up, dn, lf, rt;
    up = (b == 0) ? 8'h1A : 8'h52;
    dn = (b == 0) ? 8'h16 : 8'h51;
    lf = (b == 0) ? 8'h04 : 8'h50;
    rt = (b == 0) ? 8'h07 : 8'h4F;
    hit = 1'b1;
    mx = 0;
    my = 0;
    if (k == up)      my = -ST;
    else if (k == dn) my = ST;
    else if (k == lf) mx = -ST;
    else if (k == rt) mx = ST;
    else hit = 1'b0;
  endfunction

  function automatic int bounce(input int pos, input int mot, input int lo, input int hi);
    if (pos + SZ >= hi) return -ST;
    if (pos - SZ <= lo) return ST;
    return mot;
  endfunction

  function automatic void model_edge(input bit rst, input bit fc, input logic [7:0] k0,
                                     input logic [7:0] k1);
    bit hit0, hit1;
    int ax, ay, bx, by;
    // VSync seen high two edges ago, low three edges ago -> this edge moves
    m_tick = h2 && !h3;
    if (rst) begin
      m_x[0] = XC; m_y[0] = YC; m_x[1] = X2; m_y[1] = YC;
      for (int b = 0; b < 2; b++) begin m_mx[b] = 0; m_my[b] = 0; end
      h1 = 0; h2 = 0; h3 = 0;
      return;
    end
    if (m_tick) begin
      for (int b = 0; b < 2; b++) begin
        model_key(b, k0, hit0, ax, ay);
        model_key(b, k1, hit1, bx, by);
        if (hit0) begin m_mx[b] = ax; m_my[b] = ay; end
        else if (hit1) begin m_mx[b] = bx; m_my[b] = by; end
        m_mx[b] = bounce(m_x[b], m_mx[b], XLO, XHI);
        m_my[b] = bounce(m_y[b], m_my[b], YLO, YHI);
        m_x[b] = ((m_x[b] + m_mx[b]) % 1024 + 1024) % 1024;
        m_y[b] = ((m_y[b] + m_my[b]) % 1024 + 1024) % 1024;
      end
    end
    h3 = h2; h2 = h1; h1 = fc;
  endfunction

  // One clock: drive on the falling edge, model the rising edge, sample 1 ns later
  task automatic step(input bit rst, input bit fc, input logic [7:0] k0, input logic [7:0] k1);
    @(negedge Clk);
    Reset = rst; frame_clk = fc; keycode0 = k0; keycode1 = k1;
    @(posedge Clk);
    model_edge(rst, fc, k0, k1);
    #1;
    chk("BallX", BallX, 10'(m_x[0]));
    chk("BallY", BallY, 10'(m_y[0]));
    chk("Ball2X", Ball2X, 10'(m_x[1]));
    chk("Ball2Y", Ball2Y, 10'(m_y[1]));
    chk("Ball_size", Ball_size, 10'(SZ));
  endtask

  task automatic frame(input int hi, input int lo, input logic [7:0] k0, input logic [7:0] k1);
    for (int i = 0; i < hi; i++) step(1'b0, 1'b1, k0, k1);
    for (int i = 0; i < lo; i++) step(1'b0, 1'b0, k0, k1);
  endtask

  function automatic logic [7:0] pick_key();
    case ($urandom_range(0, 9))
      0: return 8'h1A;
      1: return 8'h16;
      2: return 8'h04;
      3: return 8'h07;
      4: return 8'h52;
      5: return 8'h51;
      6: return 8'h50;
      7: return 8'h4F;
      8: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int y0;
    logic [7:0] k0, k1;

    // Reset for two cycles, then idle frames with no keys
    step(1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    chk("rst_x", BallX, 10'd320);
    chk("rst_y", BallY, 10'd240);
    chk("rst_x2", Ball2X, 10'd160);
    chk("rst_y2", Ball2Y, 10'd240);
    chk("rst_size", Ball_size, 10'd4);
    for (int i = 0; i < 3; i++) frame(3, 3, 8'h00, 8'h00);
    chk("idle_x", BallX, 10'd320);
    chk("idle_y2", Ball2Y, 10'd240);

    // Right key on ball 1 for five frames
    for (int i = 0; i < 5; i++) frame(2, 3, 8'h07, 8'h00);
    chk("drive_x", BallX, 10'd325);
    chk("drive_x2", Ball2X, 10'd160);

    // VSync stuck high for 1000 cycles yields exactly one update
    frame(1000, 4, 8'h07, 8'h00);
    chk("long_hi_x", BallX, 10'd326);
    // Square wave: one update per period
    for (int i = 0; i < 5; i++) frame(20, 20, 8'h07, 8'h00);
    chk("square_x", BallX, 10'd331);

    // Slot 0 beats slot 1 for ball 1; ball 2 uses slot 1 when slot 0 is empty
    y0 = m_y[0];
    for (int i = 0; i < 3; i++) frame(2, 2, 8'h1A, 8'h16);
    chk("prio_y", BallY, 10'(y0 - 3));
    y0 = m_y[1];
    for (int i = 0; i < 3; i++) frame(2, 2, 8'h00, 8'h51);
    chk("slot1_y2", Ball2Y, 10'(y0 + 3));

    // Drive ball 1 down to the bottom edge, then it must bounce
    for (int i = 0; i < 400 && m_y[0] != 475; i++) frame(2, 2, 8'h16, 8'h00);
    chk("reach_y", BallY, 10'd475);
    frame(2, 2, 8'h16, 8'h00);
    chk("bounce_y", BallY, 10'd474);
    frame(2, 2, 8'h16, 8'h00);
    frame(2, 2, 8'h16, 8'h00);
    chk("bounce_hold_y", BallY, 10'd474);

    // Ball 2 moving left to 100, then reset lands on the tick cycle
    step(1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 60; i++) frame(2, 2, 8'h50, 8'h00);
    chk("left_x2", Ball2X, 10'd100);
    step(1'b0, 1'b1, 8'h50, 8'h00);
    step(1'b0, 1'b1, 8'h50, 8'h00);
    step(1'b1, 1'b1, 8'h50, 8'h00);
    chk("rst_tick_seen", 10'(m_tick), 10'd1);
    chk("rst_tick_x2", Ball2X, 10'd160);
    // Reset release with VSync already high: no immediate tick, motion cleared
    step(1'b0, 1'b1, 8'h00, 8'h00);
    chk("no_tick_x2", Ball2X, 10'd160);
    frame(3, 3, 8'h00, 8'h00);
    chk("motion0_x2", Ball2X, 10'd160);

    // Randomized segments: held key pairs, jittered frame timing, sporadic resets
    for (int s = 0; s < 30; s++) begin
      k0 = pick_key();
      k1 = pick_key();
      if ($urandom_range(0, 9) == 0) step(1'b1, 1'($urandom_range(0, 1)), k0, k1);
      for (int f = 0; f < int'($urandom_range(20, 150)); f++)
        frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), k0, k1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dual_ball_motion.md
DUAL_BALL_MOTION -- requirements
Module: dual_ball_motion

Interface
REQ-001 SHALL have parameter X_CENTER, default 320: ball 1 reset X.
REQ-002 SHALL have parameter Y_CENTER, default 240: reset Y for both balls.
REQ-003 SHALL have parameter X2_START, default 160: ball 2 reset X.
REQ-004 SHALL have parameter X_MIN/X_MAX, defaults 0/639: horizontal playfield bounds.
REQ-005 SHALL have parameter Y_MIN/Y_MAX, defaults 0/479: vertical playfield bounds.
REQ-006 SHALL have parameter STEP, default 1: pixels moved per frame.
REQ-007 SHALL have parameter SIZE, default 4: ball half-width.
REQ-008 SHALL have port Clk, input, 1: sole clock, 50 MHz.
REQ-009 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-010 SHALL have port frame_clk, input, 1: VGA VSync, asynchronous to Clk.
REQ-011 SHALL have port keycode0, input, 8: USB HID key slot 0.
REQ-012 SHALL have port keycode1, input, 8: USB HID key slot 1.
REQ-013 SHALL have port BallX, output, 10: ball 1 center X.
REQ-014 SHALL have port BallY, output, 10: ball 1 center Y.
REQ-015 SHALL have port Ball2X, output, 10: ball 2 center X.
REQ-016 SHALL have port Ball2Y, output, 10: ball 2 center Y.
REQ-017 SHALL have port Ball_size, output, 10: constant SIZE, consumed by the color mapper.

Function
REQ-018 SHALL synchronize frame_clk through two Clk flops, then a third flop for edge detect.
REQ-019 SHALL assert internal frame_tick for exactly one Clk cycle per synchronized rising edge of frame_clk.
REQ-020 SHALL hold all positions and motions constant on cycles without frame_tick.
REQ-021 SHALL, on frame_tick, compute next motion per axis per ball, then update position = position + next motion in that same cycle, visible on outputs the following cycle.
REQ-022 SHALL map ball 1 keys: W=0x1A up (Y -STEP, X 0); S=0x16 down; A=0x04 left (X -STEP, Y 0); D=0x07 right.
REQ-023 SHALL map ball 2 keys: 0x52 up; 0x51 down; 0x50 left; 0x4F right.
REQ-024 SHALL resolve each ball's key by checking keycode0 first, then keycode1; first matching key wins.
REQ-025 SHALL retain the previous motion of a ball when neither slot holds one of its keys.
REQ-026 SHALL apply boundary override after the key decode; boundary has priority over keys:
- Y+SIZE >= Y_MAX -> Y motion = -STEP
- Y-SIZE <= Y_MIN -> Y motion = +STEP
- same rule on X with X_MIN/X_MAX
REQ-027 SHALL perform all position arithmetic in 10-bit two's complement with motion registers 10 bits wide; -STEP = ~STEP+1.
REQ-028 SHALL evaluate X_MIN/Y_MIN bound checks without underflow when the position is below SIZE, using 11-bit comparison.
REQ-029 SHALL update both balls independently on the same frame_tick; overlapping balls are legal and no collision handling is performed.
REQ-030 SHALL drive Ball_size = SIZE continuously, including during reset.

Reset
REQ-031 SHALL, on any Clk edge with Reset=1, set BallX=X_CENTER, BallY=Y_CENTER, Ball2X=X2_START, Ball2Y=Y_CENTER.
REQ-032 SHALL, on reset, clear all motions to 0 and clear the synchronizer and edge flops.
REQ-033 SHALL suppress movement when Reset is asserted on a frame_tick cycle; the reset values win.
REQ-034 SHALL produce no frame_tick on the first cycle after reset release, even if frame_clk is already high.

Verification
REQ-035 SHALL verify reset: Reset high 2 cycles -> BallX=320, BallY=240, Ball2X=160, Ball2Y=240, Ball_size=4; positions unchanged after 3 frame_clk edges with no keys.
REQ-036 SHALL verify key drive: keycode0=0x07, 5 frame_clk rising edges -> BallX=325, Ball2X=160; each update occurs exactly one Clk cycle after the internal tick.
REQ-037 SHALL verify slot priority: keycode0=0x1A, keycode1=0x16 -> BallY decreases 1 per frame; keycode0=0x00, keycode1=0x51 -> Ball2Y increases 1 per frame.
REQ-038 SHALL verify bounce: BallY driven down with 0x16 to 475 -> next frame motion -1, BallY=474; bounce holds while S is pressed.
REQ-039 SHALL verify tick rate: frame_clk held high 1000 cycles -> exactly one update; a glitch-free square wave at 60 Hz -> one update per period.
REQ-040 SHALL verify reset mid-flight: ball 2 moving left at 100, Reset coincident with tick -> Ball2X=160 and motion 0 next cycle.
